// File: rtl/keypad_code_collector.sv
// Assembles hex key digits (MSB first) into a code word and hands it to the lock FSM
// over a valid/ready handshake; flags malformed entries and expires stale partial ones.
module keypad_code_collector #(
  parameter  int NUM_DIGITS = 4,
  parameter  int TIMEOUT    = 1000,
  localparam int CODE_W     = NUM_DIGITS * 4,
  localparam int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic              key_enter,
  input  logic              key_clear,
  input  logic              code_ready,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  output logic              entry_err,
  output logic              timeout,
  output logic [CNT_W-1:0]  digit_cnt
);

  localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(NUM_DIGITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_FULL,
    ST_PRESENT
  } state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   sr_q, sr_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                code_valid_q, code_valid_d;
  logic                entry_err_q, entry_err_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    digit_cnt_q, digit_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;

  logic [CODE_W-1:0]   sr_shift;
  logic [CNT_W-1:0]    digit_cnt_inc;

  // A single-digit code has no older digits to shift up.
  generate
    if (NUM_DIGITS == 1) begin : g_shift_one
      assign sr_shift = key_code;
    end else begin : g_shift_many
      assign sr_shift = {sr_q[CODE_W-5:0], key_code};
    end
  endgenerate

  assign digit_cnt_inc = digit_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    code_d       = code_q;
    code_valid_d = code_valid_q;
    entry_err_d  = 1'b0;
    timeout_d    = 1'b0;
    digit_cnt_d  = digit_cnt_q;
    idle_cnt_d   = idle_cnt_q;

    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (key_clear) begin
          sr_d        = '0;
          digit_cnt_d = '0;
          idle_cnt_d  = '0;
          state_d     = ST_IDLE;
        end else if (key_enter) begin
          entry_err_d = 1'b1;
          sr_d        = '0;
          digit_cnt_d = '0;
          idle_cnt_d  = '0;
          state_d     = ST_IDLE;
        end else if (key_valid) begin
          sr_d        = sr_shift;
          digit_cnt_d = digit_cnt_inc;
          idle_cnt_d  = '0;
          state_d     = (digit_cnt_inc == FULL_CNT) ? ST_FULL : ST_ENTRY;
        end else if (state_q == ST_ENTRY) begin
          if (idle_cnt_q == IDLE_LAST) begin
            timeout_d   = 1'b1;
            sr_d        = '0;
            digit_cnt_d = '0;
            idle_cnt_d  = '0;
            state_d     = ST_IDLE;
          end else begin
            idle_cnt_d  = idle_cnt_q + 1'b1;
          end
        end else begin
          idle_cnt_d  = '0;
        end
      end

      ST_FULL: begin
        if (key_clear) begin
          sr_d        = '0;
          digit_cnt_d = '0;
          idle_cnt_d  = '0;
          state_d     = ST_IDLE;
        end else if (key_enter) begin
          code_d       = sr_q;
          code_valid_d = 1'b1;
          sr_d         = '0;
          digit_cnt_d  = '0;
          idle_cnt_d   = '0;
          state_d      = ST_PRESENT;
        end else if (key_valid) begin
          // Extra digit is rejected but still counts as activity.
          entry_err_d = 1'b1;
          idle_cnt_d  = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          timeout_d   = 1'b1;
          sr_d        = '0;
          digit_cnt_d = '0;
          idle_cnt_d  = '0;
          state_d     = ST_IDLE;
        end else begin
          idle_cnt_d  = idle_cnt_q + 1'b1;
        end
      end

      ST_PRESENT: begin
        idle_cnt_d = '0;
        if (code_valid_q && code_ready) begin
          code_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        sr_d         = '0;
        code_valid_d = 1'b0;
        digit_cnt_d  = '0;
        idle_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      sr_q         <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      entry_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
      digit_cnt_q  <= '0;
      idle_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      entry_err_q  <= entry_err_d;
      timeout_q    <= timeout_d;
      digit_cnt_q  <= digit_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign entry_err  = entry_err_q;
  assign timeout    = timeout_q;
  assign digit_cnt  = digit_cnt_q;

endmodule

// File: tb/tb_keypad_code_collector.sv
// Directed bench for keypad_code_collector (TIMEOUT shortened to 8 cycles).
module tb_keypad_code_collector;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_enter;
  logic        key_clear;
  logic        code_ready;
  logic [15:0] code;
  logic        code_valid;
  logic        entry_err;
  logic        timeout;
  logic [2:0]  digit_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  keypad_code_collector #(
    .NUM_DIGITS(4),
    .TIMEOUT   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_enter (key_enter),
    .key_clear (key_clear),
    .code_ready(code_ready),
    .code      (code),
    .code_valid(code_valid),
    .entry_err (entry_err),
    .timeout   (timeout),
    .digit_cnt (digit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic enter();
    key_enter = 1'b1;
    tick();
    key_enter = 1'b0;
  endtask

  task automatic clear();
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    key_valid  = 1'b0;
    key_code   = 4'h0;
    key_enter  = 1'b0;
    key_clear  = 1'b0;
    code_ready = 1'b0;
    tick();
    tick();
    chk("rst_code", code, 16'h0);
    chk("rst_valid", code_valid, 0);
    chk("rst_err", entry_err, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cnt", digit_cnt, 0);
    rst = 1'b1;
    tick();

    // Full entry with ready tied high
    code_ready = 1'b1;
    press(4'hD); chk("t1_cnt1", digit_cnt, 1);
    press(4'hF); chk("t1_cnt2", digit_cnt, 2);
    press(4'h6); chk("t1_cnt3", digit_cnt, 3);
    press(4'hF); chk("t1_cnt4", digit_cnt, 4);
    enter();
    chk("t1_valid", code_valid, 1);
    chk("t1_code", code, 16'hDF6F);
    chk("t1_cnt0", digit_cnt, 0);
    chk("t1_err", entry_err, 0);
    tick();
    chk("t1_valid_drop", code_valid, 0);
    chk("t1_code_hold", code, 16'hDF6F);

    // Back-pressure: strobes ignored while presenting
    code_ready = 1'b0;
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    enter();
    chk("t2_valid", code_valid, 1);
    chk("t2_code", code, 16'h1234);
    press(4'h9); chk("t2_hold1", code_valid, 1); chk("t2_err1", entry_err, 0);
    press(4'h9); chk("t2_hold2", code_valid, 1); chk("t2_cnt2", digit_cnt, 0);
    clear();     chk("t2_hold3", code_valid, 1); chk("t2_code3", code, 16'h1234);
    tick();      chk("t2_hold4", code_valid, 1);
    tick();      chk("t2_hold5", code_valid, 1); chk("t2_code5", code, 16'h1234);
    code_ready = 1'b1;
    tick();
    chk("t2_drop", code_valid, 0);
    chk("t2_cnt_after", digit_cnt, 0);
    chk("t2_code_keep", code, 16'h1234);

    // Short entry, then enter from IDLE
    press(4'hA); press(4'hB);
    enter();
    chk("t3_err", entry_err, 1);
    chk("t3_cnt", digit_cnt, 0);
    chk("t3_valid", code_valid, 0);
    tick();
    chk("t3_err_pulse", entry_err, 0);
    chk("t3_valid2", code_valid, 0);
    enter();
    chk("t3_idle_err", entry_err, 1);
    tick();
    chk("t3_idle_err_pulse", entry_err, 0);

    // Fifth digit rejected
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    chk("t4_err_none", entry_err, 0);
    press(4'h5);
    chk("t4_err5", entry_err, 1);
    chk("t4_cnt5", digit_cnt, 4);
    enter();
    chk("t4_err_clr", entry_err, 0);
    chk("t4_valid", code_valid, 1);
    chk("t4_code", code, 16'h1234);
    tick();
    chk("t4_drop", code_valid, 0);

    // Timeout after 8 idle cycles
    press(4'h7);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("t5_no_to_%0d", i), timeout, 0);
    end
    chk("t5_cnt_held", digit_cnt, 1);
    tick();
    chk("t5_timeout", timeout, 1);
    chk("t5_cnt0", digit_cnt, 0);
    tick();
    chk("t5_timeout_pulse", timeout, 0);

    // Key at cycle 7 keeps the entry alive
    press(4'h7);
    for (int i = 1; i <= 6; i++) tick();
    press(4'h3);
    chk("t5b_cnt2", digit_cnt, 2);
    tick();
    chk("t5b_no_to", timeout, 0);
    chk("t5b_cnt2_hold", digit_cnt, 2);
    clear();
    chk("t5b_clear", digit_cnt, 0);

    // Simultaneous clear/enter/digit: clear wins
    press(4'h1); press(4'h2); press(4'h3);
    chk("t6_cnt3", digit_cnt, 3);
    key_clear = 1'b1; key_enter = 1'b1; key_valid = 1'b1; key_code = 4'h9;
    tick();
    key_clear = 1'b0; key_enter = 1'b0; key_valid = 1'b0;
    chk("t6_cnt0", digit_cnt, 0);
    chk("t6_err", entry_err, 0);
    chk("t6_valid", code_valid, 0);
    tick();
    chk("t6_err_after", entry_err, 0);

    // Asynchronous reset while presenting
    code_ready = 1'b0;
    press(4'hC); press(4'hA); press(4'hF); press(4'hE);
    enter();
    chk("t7_valid", code_valid, 1);
    chk("t7_code", code, 16'hCAFE);
    #2;
    rst = 1'b0;
    #1;
    chk("t7_async_valid", code_valid, 0);
    chk("t7_async_code", code, 16'h0);
    chk("t7_async_cnt", digit_cnt, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("t7_post_valid", code_valid, 0);
    chk("t7_post_err", entry_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_code_collector.md
Name: keypad_code_collector

Overview:
- Upstream stage of the door-lock FSM.
- Takes single-digit key events from the keypad scanner and assembles NUM_DIGITS hex digits, MSB first, into a CODE_W-bit code word.
- Presents the word to the lock FSM on a valid/ready handshake.
- Flags malformed entries and abandons stale partial entries after an inactivity timeout.

Parameters:
- NUM_DIGITS, 4, digits per code. CODE_W = NUM_DIGITS*4 is derived; 16 at default.
- TIMEOUT, 1000, idle clock cycles allowed between keys before a partial entry is discarded (≥2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- key_valid  input  1  one-cycle strobe: key_code holds a digit.
- key_code  input  4  hex digit 0x0–0xF.
- key_enter  input  1  one-cycle strobe: submit entry.
- key_clear  input  1  one-cycle strobe: abandon entry.
- code_ready  input  1  lock FSM accepts code this cycle.
- code  output  CODE_W  assembled code word.
- code_valid  output  1  code is presented.
- entry_err  output  1  one-cycle pulse: malformed entry.
- timeout  output  1  one-cycle pulse: partial entry expired.
- digit_cnt  output  clog2(NUM_DIGITS+1)  digits currently held.

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE; shift register = 0.
  - code = 0; code_valid, entry_err, timeout = 0; digit_cnt = 0; idle counter = 0.
- All outputs are registered. Inputs are synchronous to clk.
- States: IDLE (0 digits), ENTRY (1..NUM_DIGITS-1 digits), FULL (NUM_DIGITS digits), PRESENT (handshake pending).
- Same-cycle priority among key_clear, key_enter, key_valid: clear > enter > digit. Lower-priority strobes in that cycle are dropped.
- Digit accept (IDLE/ENTRY):
  - sr <= {sr[CODE_W-5:0], key_code}; digit_cnt+1.
  - Goes to ENTRY, or to FULL when the count reaches NUM_DIGITS.
  - Visible on digit_cnt the next cycle.
- Digit in FULL: ignored; sr unchanged; entry_err pulses 1 cycle; stays FULL.
- key_enter in FULL:
  - next cycle code <= sr, code_valid = 1, state PRESENT.
  - sr and digit_cnt clear to 0.
  - Latency: enter sampled edge N → code_valid high after edge N.
- key_enter in IDLE/ENTRY (short entry): entry_err pulses; sr and digit_cnt clear; → IDLE.
- key_clear in IDLE/ENTRY/FULL: sr and digit_cnt clear; → IDLE; no error pulse.
- PRESENT:
  - code and code_valid held stable until code_ready = 1 is sampled with code_valid = 1.
  - Next cycle code_valid = 0 and state IDLE. code keeps its last value.
  - All key strobes (including clear) are ignored in PRESENT; no error pulse.
  - code_ready while code_valid = 0 has no effect.
- Timeout:
  - Idle counter runs only in ENTRY/FULL.
  - Reset to 0 on any accepted or ignored key strobe, and on entering ENTRY.
  - When the counter reaches TIMEOUT-1 with no strobe: timeout pulses 1 cycle; sr and digit_cnt clear; → IDLE.
  - A strobe in the expiring cycle wins; no timeout.
  - Counter frozen at 0 in IDLE/PRESENT.
- entry_err and timeout never assert in the same cycle. Neither asserts while code_valid = 1.
- Reset mid-entry or mid-handshake: immediate return to reset values. A pending code is dropped, with no pulse.

Test Plan:
- Keys D,F,6,F then enter, code_ready tied 1 → code = 16'hDF6F, code_valid high exactly 1 cycle, digit_cnt 4→0, no error.
- Keys 1,2,3,4, enter, code_ready held 0 for 5 cycles, keys 9,9 and clear pressed meanwhile → code_valid held 6 cycles at 16'h1234, strobes ignored, drops the cycle after ready.
- Keys A,B then enter → entry_err 1-cycle pulse, digit_cnt 0, code_valid never asserts. Then enter from IDLE → entry_err pulses again.
- Keys 1,2,3,4,5 → entry_err on the 5th key, then enter → code = 16'h1234.
- TIMEOUT=8: key 7, no further keys → timeout pulses 8 cycles later, digit_cnt 0. Repeat with a key at cycle 7 → no timeout, digit_cnt 2.
- key_clear+key_enter+key_valid in the same cycle with 3 digits held → cleared, no entry_err. Assert rst low during PRESENT → code_valid drops asynchronously, code = 0.
